// File: rtl/cacheline_adaptor.sv
// rtl/cacheline_adaptor.sv - cache line <-> memory burst adaptor (optional checker: CACHELINE_ADAPTOR_PROTOCOL_CHECK_EN)
// Splits a cache line into s_line/s_burst memory beats for writes and assembles beats into a line for reads.
module cacheline_adaptor #(
    parameter int s_line  = 256,
    parameter int s_burst = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [s_line-1:0]  line_i,
    output logic [s_line-1:0]  line_o,
    input  logic [31:0]        address_i,
    input  logic               read_i,
    input  logic               write_i,
    output logic               resp_o,
    input  logic [s_burst-1:0] burst_i,
    output logic [s_burst-1:0] burst_o,
    output logic [31:0]        address_o,
    output logic               read_o,
    output logic               write_o,
    input  logic               resp_i,
    output logic               err_o
);

    localparam int BEATS = s_line / s_burst;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RD_BURST,
        WR_BURST,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     beat_q, beat_d;
    logic [31:0]       addr_q, addr_d;
    logic [s_line-1:0] line_q, line_d;
    logic [s_line-1:0] buf_q, buf_d;
    logic              last_beat;

    // The line offset bits never reach memory; the address is always line-aligned.
    logic unused_addr_bits;
    assign unused_addr_bits = ^address_i[4:0];

    assign last_beat = (beat_q == CW'(BEATS - 1));

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        addr_d  = addr_q;
        line_d  = line_q;
        buf_d   = buf_q;
        case (state_q)
            IDLE: begin
                if (read_i) begin
                    state_d = RD_BURST;
                    beat_d  = '0;
                    addr_d  = {address_i[31:5], 5'b0};
                end else if (write_i) begin
                    state_d = WR_BURST;
                    beat_d  = '0;
                    addr_d  = {address_i[31:5], 5'b0};
                    buf_d   = line_i;
                end
            end
            RD_BURST: begin
                if (resp_i) begin
                    line_d[int'(beat_q) * s_burst +: s_burst] = burst_i;
                    beat_d = beat_q + CW'(1);
                    if (last_beat) begin
                        state_d = DONE;
                    end
                end
            end
            WR_BURST: begin
                // Shifting keeps the outgoing beat in the low slice of the buffer.
                if (resp_i) begin
                    buf_d  = buf_q >> s_burst;
                    beat_d = beat_q + CW'(1);
                    if (last_beat) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            addr_q  <= '0;
            line_q  <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            addr_q  <= addr_d;
            line_q  <= line_d;
            buf_q   <= buf_d;
        end
    end

    assign read_o    = (state_q == RD_BURST);
    assign write_o   = (state_q == WR_BURST);
    assign resp_o    = (state_q == DONE);
    assign burst_o   = write_o ? buf_q[s_burst-1:0] : '0;
    assign address_o = addr_q;
    assign line_o    = line_q;

`ifdef CACHELINE_ADAPTOR_PROTOCOL_CHECK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (resp_i && (state_q == IDLE || state_q == DONE)) begin
            err_d = 1'b1;
        end
        if (state_q == IDLE && read_i && write_i) begin
            err_d = 1'b1;
        end
        if ((state_q == RD_BURST && !read_i) || (state_q == WR_BURST && !write_i)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule
